ddr3_fill_writer: RTL and testbench
===================================

// Module: ddr3_fill_writer
// PURPOSE
//  Parametrised successor to the fill write controller. Drains fills from the ADC first-word-fall-through
//  (FWFT) FIFO into DDR3 via the MIG user interface. Each fill is header, BURSTS payload words, checksum.
//  Address and data channels run independently with full ready/valid backpressure and no fixed
//  retry-window limit. On completion the header is pushed to the fill-header FIFO, gated by that FIFO's full flag.
// PARAMETERS
//  DATA_W    128  FIFO / app_wdf_data width; header tag is [DATA_W-1:DATA_W-2]
//  AGEN_W    23   address generator width; wraps modulo 2^AGEN_W
//  ADDR_SHIFT 3   zero LSBs appended: app_addr = {agen, ADDR_SHIFT'b0}
//  ADDR_LSB  35   header bit position of start address field (AGEN_W bits)
//  LEN_W     21   burst count field width (header bits [LEN_LSB+LEN_W-1:LEN_LSB])
//  LEN_LSB   64   header bit position of burst count field
//  CNT_W     16   width of completed-fill counter
// PORTS
//  clk              in   1        DDR3 user-interface clock
//  reset            in   1        synchronous, active-high
//  acq_enabled      in   1        permits start of a new fill
//  fifo_dat         in   DATA_W   FWFT FIFO head word
//  fifo_empty       in   1        FIFO empty
//  fifo_rd_en       out  1        pop FIFO head (= app_wdf_wren & app_wdf_rdy)
//  app_wdf_data     out  DATA_W   = fifo_dat
//  app_wdf_wren     out  1        write-data valid
//  app_wdf_end      out  1        = app_wdf_wren (one beat per burst)
//  app_wdf_rdy      in   1        MIG accepts data
//  app_en           out  1        write-command valid
//  app_addr         out  AGEN_W+ADDR_SHIFT  command address
//  app_rdy          in   1        MIG accepts command
//  hdr_dat          out  DATA_W   latched header of current fill
//  hdr_wr_en        out  1        1-cycle push to fill-header FIFO
//  hdr_full         in   1        fill-header FIFO full
//  sync_err         out  1        sticky: bad header tag
//  busy             out  1        high in any state except IDLE and ERR
//  fills_done       out  CNT_W    completed fills; wraps
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 except the pass-throughs app_wdf_data/fifo_dat; counters, agen and hdr_dat cleared.
//  States:
//   IDLE  -> HDR when acq_enabled & !fifo_empty
//   HDR   (1 cycle, FIFO not popped)
//         if fifo_dat tag==2'b01: latch hdr_dat, agen<=start field, dcnt=ccnt<=BURSTS+2 (LEN_W+1 bits, no overflow) -> WRITE
//         else -> ERR
//   WRITE -> DONE when dcnt==0 & ccnt==0
//   DONE  hold while hdr_full; hdr_wr_en=1 for exactly the one cycle hdr_full==0, fills_done++ -> IDLE
//   ERR   sync_err=1, terminal until reset; nothing issued
//  Data channel (combinational from registered state):
//   app_wdf_wren = WRITE & dcnt!=0 & !fifo_empty
//   dcnt-- on wren&rdy
//   the header word is itself the first data word written
//  Command channel:
//   app_en = WRITE & ccnt!=0
//   on en&rdy: ccnt--, agen++ (wraps to 0 past 2^AGEN_W-1)
//   channels are fully independent: either may lead the other by any amount
//  Backpressure: valid held while its rdy is low; no retry limit. FIFO empty mid-fill: wren drops, command channel continues.
//  acq_enabled low: has effect only in IDLE. A fill in progress always completes.
//  Simultaneous: final data and final command accepted in the same cycle -> DONE on next cycle.
//  Reset mid-fill: immediate return to IDLE. FIFO contents are not flushed (upstream resets FIFO).
// TESTING
//  1) BURSTS=0, start=0x100, rdy always 1
//     -> 2 data beats, addrs 0x800,0x808; hdr_wr_en 1 pulse; fills_done=1
//  2) BURSTS=4, app_rdy low 5 cycles at beat 2
//     -> app_en held, addr not advanced; 6 writes total; no lost/duplicated data
//  3) BURSTS=8, FIFO empties after 3 words for 10 cycles
//     -> wren low during gap, commands continue; completes with 10 data and 10 commands
//  4) Header tag 2'b10 -> ERR, sync_err=1 sticky, no app_en/wren, fifo_rd_en=0 until reset
//  5) start=0x7FFFFF, BURSTS=1 -> agen wraps to 0 after first command; app_addr 0x3FFFFF8 then 0x0, then 0x8
//  6) hdr_full high 7 cycles at DONE
//     -> hdr_wr_en held off, then single pulse; two back-to-back fills -> fills_done=2

Source files
------------

// File: rtl/ddr3_fill_writer.sv
// ddr3_fill_writer
//   Drains fills (header, BURSTS payload words, checksum) from an ADC FWFT
//   FIFO into DDR3 through the MIG user interface. The address and data
//   channels run independently under ready/valid backpressure. When a fill
//   completes, its header is pushed to the fill-header FIFO.
//
// Ports
//   clk, reset                   UI clock, synchronous active-high reset
//   acq_enabled                  permits the start of a new fill (IDLE only)
//   fifo_dat, fifo_empty         FWFT FIFO head word and empty flag
//   fifo_rd_en                   pops the FIFO head when a data beat is accepted
//   app_wdf_data/wren/end/rdy    MIG write-data channel
//   app_en, app_addr, app_rdy    MIG command channel
//   hdr_dat, hdr_wr_en, hdr_full header of the current fill and its FIFO push
//   sync_err                     sticky bad-header-tag flag
//   busy                         fill in progress (not IDLE, not ERR)
//   fills_done                   count of completed fills, wraps
module ddr3_fill_writer #(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned AGEN_W     = 23,
    parameter int unsigned ADDR_SHIFT = 3,
    parameter int unsigned ADDR_LSB   = 35,
    parameter int unsigned LEN_W      = 21,
    parameter int unsigned LEN_LSB    = 64,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         acq_enabled,
    input  logic [DATA_W-1:0]            fifo_dat,
    input  logic                         fifo_empty,
    output logic                         fifo_rd_en,
    output logic [DATA_W-1:0]            app_wdf_data,
    output logic                         app_wdf_wren,
    output logic                         app_wdf_end,
    input  logic                         app_wdf_rdy,
    output logic                         app_en,
    output logic [AGEN_W+ADDR_SHIFT-1:0] app_addr,
    input  logic                         app_rdy,
    output logic [DATA_W-1:0]            hdr_dat,
    output logic                         hdr_wr_en,
    input  logic                         hdr_full,
    output logic                         sync_err,
    output logic                         busy,
    output logic [CNT_W-1:0]             fills_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    logic [LEN_W:0]    dcnt;
    logic [LEN_W:0]    ccnt;
    logic [LEN_W:0]    dcnt_nxt;
    logic [LEN_W:0]    ccnt_nxt;
    logic [LEN_W:0]    burst_total;
    logic [AGEN_W-1:0] agen;
    logic              data_fire;
    logic              cmd_fire;

    // Header + payload + checksum beats; one extra bit so BURSTS+2 cannot overflow.
    assign burst_total = {1'b0, fifo_dat[LEN_LSB +: LEN_W]} + (LEN_W+1)'(2);

    assign app_wdf_data = fifo_dat;
    assign app_wdf_wren = (state == S_WRITE) && (dcnt != '0) && !fifo_empty;
    assign app_wdf_end  = app_wdf_wren;
    assign app_en       = (state == S_WRITE) && (ccnt != '0);
    assign app_addr     = {agen, {ADDR_SHIFT{1'b0}}};
    assign data_fire    = app_wdf_wren && app_wdf_rdy;
    assign cmd_fire     = app_en && app_rdy;
    assign fifo_rd_en   = data_fire;
    assign hdr_wr_en    = (state == S_DONE) && !hdr_full;
    assign sync_err     = (state == S_ERR);
    assign busy         = (state == S_HDR) || (state == S_WRITE) || (state == S_DONE);

    always_comb begin
        dcnt_nxt = dcnt - (LEN_W+1)'(data_fire);
        ccnt_nxt = ccnt - (LEN_W+1)'(cmd_fire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            dcnt       <= '0;
            ccnt       <= '0;
            agen       <= '0;
            hdr_dat    <= '0;
            fills_done <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (acq_enabled && !fifo_empty) state <= S_HDR;
                end
                // Header stays at the FIFO head; it is written as the first data beat.
                S_HDR: begin
                    if (fifo_dat[DATA_W-1 -: 2] == 2'b01) begin
                        hdr_dat <= fifo_dat;
                        agen    <= fifo_dat[ADDR_LSB +: AGEN_W];
                        dcnt    <= burst_total;
                        ccnt    <= burst_total;
                        state   <= S_WRITE;
                    end else begin
                        state <= S_ERR;
                    end
                end
                // Completion is judged on post-handshake counts so that final beats
                // accepted together move straight to DONE on the next cycle.
                S_WRITE: begin
                    dcnt <= dcnt_nxt;
                    ccnt <= ccnt_nxt;
                    if (cmd_fire) agen <= agen + AGEN_W'(1);
                    if (dcnt_nxt == '0 && ccnt_nxt == '0) state <= S_DONE;
                end
                S_DONE: begin
                    if (!hdr_full) begin
                        fills_done <= fills_done + CNT_W'(1);
                        state      <= S_IDLE;
                    end
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_fill_writer.sv
module tb_ddr3_fill_writer;

    localparam int DATA_W = 128;
    localparam int AGEN_W = 23;
    localparam int AW     = AGEN_W + 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              acq_enabled;
    logic [DATA_W-1:0] fifo_dat;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] app_wdf_data;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic              app_wdf_rdy;
    logic              app_en;
    logic [AW-1:0]     app_addr;
    logic              app_rdy;
    logic [DATA_W-1:0] hdr_dat;
    logic              hdr_wr_en;
    logic              hdr_full;
    logic              sync_err;
    logic              busy;
    logic [15:0]       fills_done;

    ddr3_fill_writer #(
        .DATA_W(128), .AGEN_W(23), .ADDR_SHIFT(3), .ADDR_LSB(35),
        .LEN_W(21), .LEN_LSB(64), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .acq_enabled(acq_enabled),
        .fifo_dat(fifo_dat), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_en(app_en), .app_addr(app_addr), .app_rdy(app_rdy),
        .hdr_dat(hdr_dat), .hdr_wr_en(hdr_wr_en), .hdr_full(hdr_full),
        .sync_err(sync_err), .busy(busy), .fills_done(fills_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: FIFO contents and expected / observed transfers.
    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_data[$];
    logic [DATA_W-1:0] got_data[$];
    logic [DATA_W-1:0] exp_hdr[$];
    logic [DATA_W-1:0] got_hdr[$];
    logic [AW-1:0]     exp_addr[$];
    logic [AW-1:0]     got_addr[$];
    int                exp_fills;
    int                hdr_pulses;

    // Stimulus knobs.
    bit rand_rdy;
    int stall_at, stall_left;
    int gap_after, gap_left, gap_cmds, popped;
    int hold_left;
    bit force_empty;

    // Handshake-stability tracking.
    bit          prev_cmd_stall, prev_dat_stall;
    logic [AW-1:0]     prev_addr;
    logic [DATA_W-1:0] prev_data;

    function automatic logic [DATA_W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clear_logs();
        exp_data.delete(); got_data.delete();
        exp_hdr.delete();  got_hdr.delete();
        exp_addr.delete(); got_addr.delete();
        hdr_pulses = 0; popped = 0; gap_cmds = 0;
        prev_cmd_stall = 0; prev_dat_stall = 0;
    endtask

    // Appends one fill to the FIFO and derives its expected transfers from
    // the fill format: every word in order, addresses start..start+B+1 mod 2^23.
    task automatic push_fill(input int unsigned start, input int unsigned bursts,
                             input logic [1:0] tag);
        logic [DATA_W-1:0] h;
        logic [AGEN_W-1:0] a;
        h = rand128();
        h[127:126] = tag;
        h[35 +: 23] = start[22:0];
        h[64 +: 21] = bursts[20:0];
        fifo_q.push_back(h);
        exp_data.push_back(h);
        exp_hdr.push_back(h);
        for (int i = 0; i < int'(bursts) + 1; i++) begin
            h = rand128();
            fifo_q.push_back(h);
            exp_data.push_back(h);
        end
        for (int i = 0; i < int'(bursts) + 2; i++) begin
            a = AGEN_W'(start + i);
            exp_addr.push_back({a, 3'b000});
        end
    endtask

    task automatic drive_inputs();
        force_empty = 0;
        if (gap_after >= 0 && popped == gap_after && gap_left > 0) begin
            force_empty = 1;
            gap_left--;
        end
        fifo_empty = force_empty || (fifo_q.size() == 0);
        fifo_dat   = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        if (stall_at >= 0 && got_addr.size() == stall_at && stall_left > 0) begin
            app_rdy = 0;
            stall_left--;
        end else begin
            app_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        app_wdf_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (got_data.size() == exp_data.size() && got_addr.size() == exp_addr.size()
            && hold_left > 0) hold_left--;
        hdr_full = (hold_left > 0);
    endtask

    // One clock: observe at the falling edge, update inputs just after the rising edge.
    task automatic step();
        bit pop;
        @(negedge clk);
        checks++;
        if (fifo_rd_en !== (app_wdf_wren & app_wdf_rdy) || app_wdf_end !== app_wdf_wren
            || app_wdf_data !== fifo_dat) begin
            failures++;
            $display("FAIL handshake rd_en=%b end=%b wren=%b rdy=%b data_ok=%b",
                     fifo_rd_en, app_wdf_end, app_wdf_wren, app_wdf_rdy, app_wdf_data === fifo_dat);
        end
        checks++;
        if (fifo_empty && app_wdf_wren) begin
            failures++;
            $display("FAIL wren_while_empty wren=%b want 0", app_wdf_wren);
        end
        checks++;
        if (hdr_full && hdr_wr_en) begin
            failures++;
            $display("FAIL hdr_wr_en_while_full hdr_wr_en=%b want 0", hdr_wr_en);
        end
        if (prev_cmd_stall) begin
            checks++;
            if (!app_en || app_addr !== prev_addr) begin
                failures++;
                $display("FAIL cmd_hold app_en=%b addr=%h want 1 %h", app_en, app_addr, prev_addr);
            end
        end
        if (prev_dat_stall && !fifo_empty) begin
            checks++;
            if (!app_wdf_wren || app_wdf_data !== prev_data) begin
                failures++;
                $display("FAIL data_hold wren=%b data=%h want 1 %h", app_wdf_wren, app_wdf_data, prev_data);
            end
        end
        if (app_wdf_wren && app_wdf_rdy) got_data.push_back(app_wdf_data);
        if (app_en && app_rdy) begin
            got_addr.push_back(app_addr);
            if (force_empty) gap_cmds++;
        end
        if (hdr_wr_en) begin
            hdr_pulses++;
            got_hdr.push_back(hdr_dat);
        end
        prev_cmd_stall = app_en && !app_rdy;
        prev_dat_stall = app_wdf_wren && !app_wdf_rdy;
        prev_addr = app_addr;
        prev_data = app_wdf_data;
        pop = fifo_rd_en;
        @(posedge clk);
        #1;
        if (pop && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            popped++;
        end
        drive_inputs();
    endtask

    task automatic apply_reset();
        reset = 1; acq_enabled = 0;
        fifo_q.delete(); clear_logs();
        rand_rdy = 0; stall_at = -1; stall_left = 0;
        gap_after = -1; gap_left = 0; hold_left = 0;
        exp_fills = 0;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic run_fills(input string name, input int n, input int budget);
        int cyc;
        cyc = 0;
        hdr_pulses = 0;
        acq_enabled = 1;
        drive_inputs();
        while (hdr_pulses < n && cyc < budget) begin
            step();
            cyc++;
        end
        repeat (3) step();
        exp_fills += n;
        checks++;
        if (hdr_pulses != n) begin
            failures++;
            $display("FAIL %s hdr_pulses=%0d want %0d (cycles=%0d)", name, hdr_pulses, n, cyc);
        end
        checks++;
        if (got_data.size() != exp_data.size()) begin
            failures++;
            $display("FAIL %s data_count=%0d want %0d", name, got_data.size(), exp_data.size());
        end else begin
            for (int i = 0; i < exp_data.size(); i++) begin
                checks++;
                if (got_data[i] !== exp_data[i]) begin
                    failures++;
                    $display("FAIL %s data[%0d]=%h want %h", name, i, got_data[i], exp_data[i]);
                end
            end
        end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            failures++;
            $display("FAIL %s cmd_count=%0d want %0d", name, got_addr.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                checks++;
                if (got_addr[i] !== exp_addr[i]) begin
                    failures++;
                    $display("FAIL %s addr[%0d]=%h want %h", name, i, got_addr[i], exp_addr[i]);
                end
            end
        end
        if (got_hdr.size() == exp_hdr.size()) begin
            for (int i = 0; i < exp_hdr.size(); i++) begin
                checks++;
                if (got_hdr[i] !== exp_hdr[i]) begin
                    failures++;
                    $display("FAIL %s hdr_dat[%0d]=%h want %h", name, i, got_hdr[i], exp_hdr[i]);
                end
            end
        end
        checks++;
        if (fills_done !== 16'(exp_fills) || busy !== 1'b0 || sync_err !== 1'b0) begin
            failures++;
            $display("FAIL %s fills_done=%0d busy=%b sync_err=%b want %0d 0 0",
                     name, fills_done, busy, sync_err, exp_fills);
        end
        clear_logs();
    endtask

    task automatic test_reset();
        reset = 1; acq_enabled = 1;
        fifo_q.delete();
        fifo_q.push_back(rand128());
        drive_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({fifo_rd_en, app_wdf_wren, app_wdf_end, app_en, hdr_wr_en, sync_err, busy} !== 7'b0
            || app_addr !== '0 || hdr_dat !== '0 || fills_done !== '0 || app_wdf_data !== fifo_dat) begin
            failures++;
            $display("FAIL reset flags=%b addr=%h hdr=%h fills=%0d want all zero",
                     {fifo_rd_en, app_wdf_wren, app_wdf_end, app_en, hdr_wr_en, sync_err, busy},
                     app_addr, hdr_dat, fills_done);
        end
        apply_reset();
    endtask

    task automatic test_min_fill();
        push_fill(32'h100, 0, 2'b01);
        acq_enabled = 0;
        drive_inputs();
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || app_en !== 1'b0 || fifo_rd_en !== 1'b0) begin
                failures++;
                $display("FAIL acq_gate busy=%b app_en=%b rd_en=%b want 0 0 0", busy, app_en, fifo_rd_en);
            end
        end
        run_fills("min_fill", 1, 100);
    endtask

    task automatic test_cmd_backpressure();
        push_fill($urandom_range(0, 32'h3FFFFF), 4, 2'b01);
        stall_at = 2; stall_left = 5;
        run_fills("cmd_backpressure", 1, 200);
        stall_at = -1;
    endtask

    task automatic test_fifo_gap();
        push_fill($urandom_range(0, 32'h3FFFFF), 8, 2'b01);
        gap_after = 3; gap_left = 10;
        run_fills("fifo_gap", 1, 300);
        gap_after = -1;
    endtask

    task automatic test_fifo_gap_cmds();
        push_fill(32'h1234, 8, 2'b01);
        gap_after = 2; gap_left = 6;
        app_rdy = 0;
        acq_enabled = 1;
        drive_inputs();
        repeat (40) step();
        checks++;
        if (gap_cmds == 0) begin
            failures++;
            $display("FAIL gap_cmds=%0d want >0", gap_cmds);
        end
        gap_after = -1;
        repeat (20) step();
        exp_fills += 1;
        checks++;
        if (fills_done !== 16'(exp_fills)) begin
            failures++;
            $display("FAIL gap_fill_done fills_done=%0d want %0d", fills_done, exp_fills);
        end
        clear_logs();
    endtask

    task automatic test_addr_wrap();
        push_fill(32'h7FFFFF, 1, 2'b01);
        run_fills("addr_wrap", 1, 100);
    endtask

    task automatic test_hdr_full();
        push_fill($urandom_range(0, 32'h7FFFFF), 2, 2'b01);
        hold_left = 7;
        run_fills("hdr_full", 1, 200);
    endtask

    task automatic test_back_to_back();
        push_fill($urandom_range(0, 32'h7FFFFF), 3, 2'b01);
        push_fill($urandom_range(0, 32'h7FFFFF), 5, 2'b01);
        run_fills("back_to_back", 2, 300);
    endtask

    task automatic test_random();
        rand_rdy = 1;
        for (int i = 0; i < 6; i++) begin
            push_fill((i % 2 == 0) ? 32'h7FFFFF - $urandom_range(0, 4) : $urandom_range(0, 32'h7FFFFF),
                      $urandom_range(0, 10), 2'b01);
            if (i % 3 == 2) hold_left = $urandom_range(1, 6);
            run_fills("random", 1, 500);
        end
        rand_rdy = 0;
    endtask

    task automatic test_reset_mid_fill();
        rand_rdy = 1;
        push_fill(32'h55, 10, 2'b01);
        acq_enabled = 1;
        drive_inputs();
        repeat (6) step();
        apply_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || app_en !== 1'b0 || app_wdf_wren !== 1'b0 || fills_done !== '0) begin
            failures++;
            $display("FAIL reset_mid_fill busy=%b app_en=%b wren=%b fills=%0d want 0 0 0 0",
                     busy, app_en, app_wdf_wren, fills_done);
        end
        push_fill(32'h200, 1, 2'b01);
        run_fills("after_reset", 1, 100);
    endtask

    task automatic test_bad_tag();
        push_fill(32'h10, 2, 2'b10);
        acq_enabled = 1;
        drive_inputs();
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || fifo_rd_en !== 1'b0 || hdr_wr_en !== 1'b0) begin
                failures++;
                $display("FAIL bad_tag_quiet app_en=%b wren=%b rd_en=%b hdr_wr_en=%b want 0 0 0 0",
                         app_en, app_wdf_wren, fifo_rd_en, hdr_wr_en);
            end
        end
        checks++;
        if (sync_err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bad_tag sync_err=%b busy=%b want 1 0", sync_err, busy);
        end
        acq_enabled = 0;
        repeat (10) @(negedge clk);
        checks++;
        if (sync_err !== 1'b1) begin
            failures++;
            $display("FAIL sync_err_sticky sync_err=%b want 1", sync_err);
        end
        apply_reset();
        @(negedge clk);
        checks++;
        if (sync_err !== 1'b0) begin
            failures++;
            $display("FAIL sync_err_reset sync_err=%b want 0", sync_err);
        end
    endtask

    initial begin
        reset = 1;
        acq_enabled = 0;
        rand_rdy = 0; stall_at = -1; stall_left = 0;
        gap_after = -1; gap_left = 0; hold_left = 0; exp_fills = 0;
        clear_logs();
        test_reset();
        test_min_fill();
        test_cmd_backpressure();
        test_fifo_gap();
        test_fifo_gap_cmds();
        test_addr_wrap();
        test_hdr_full();
        test_back_to_back();
        test_random();
        test_reset_mid_fill();
        test_bad_tag();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
